traffic_lights_cmd_rx: RTL and testbench

//  Upstream command framer for the traffic-light controller.
//  - Assembles header/data bytes from a byte stream (UART/SPI deserializer) into one command.
//  - Drives the controller's cmd_type/cmd_val/cmd_data inputs directly.
//  - Checks frames and rejects malformed, out-of-range or stalled ones.

---
 rtl/traffic_lights_cmd_rx.sv | 189 ++++++++++++++++++
 tb/tb_traffic_lights_cmd_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_cmd_rx.sv
// rtl/traffic_lights_cmd_rx.sv - byte-stream command framer for the traffic-light controller
// Optional checksum byte enabled by defining CMD_RX_CHECKSUM_EN.
module traffic_lights_cmd_rx #(
    parameter logic [3:0] SYNC_NIBBLE    = 4'hA,
    parameter int         CMD_TYPE_MAX   = 5,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_val_i,
    output logic        byte_rdy_o,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_val_o,
    output logic        frame_err_o,
    output logic [7:0]  err_cnt_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CMD_RX_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CHK, S_EMIT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_EMIT} state_t;
`endif

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  type_q, type_d;
    logic [7:0]  hi_q, hi_d;
    logic [2:0]  cmd_type_q, cmd_type_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic        cmd_val_q, cmd_val_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        rdy_q, rdy_d;
`ifdef CMD_RX_CHECKSUM_EN
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  chk_exp;
`endif

    logic accept;
    logic hdr_ok;
    logic timeout;

    assign accept  = byte_val_i && rdy_q;
    assign hdr_ok  = (byte_data_i[7:4] == SYNC_NIBBLE) && !byte_data_i[3]
                     && (int'(byte_data_i[2:0]) <= CMD_TYPE_MAX);
    // Last idle cycle before the frame is abandoned; an accept here still wins.
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`ifdef CMD_RX_CHECKSUM_EN
    assign chk_exp = {SYNC_NIBBLE, 1'b0, type_q} ^ hi_q ^ lo_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        type_d     = type_q;
        hi_d       = hi_q;
        cmd_type_d = cmd_type_q;
        cmd_data_d = cmd_data_q;
        cmd_val_d  = 1'b0;
        err_d      = 1'b0;
`ifdef CMD_RX_CHECKSUM_EN
        lo_d       = lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (hdr_ok) begin
                        type_d  = byte_data_i[2:0];
                        state_d = S_HI;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = byte_data_i;
                    cnt_d   = '0;
                    state_d = S_LO;
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LO: begin
                if (accept) begin
                    cnt_d = '0;
`ifdef CMD_RX_CHECKSUM_EN
                    lo_d    = byte_data_i;
                    state_d = S_CHK;
`else
                    cmd_type_d = type_q;
                    cmd_data_d = {hi_q, byte_data_i};
                    cmd_val_d  = 1'b1;
                    state_d    = S_EMIT;
`endif
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef CMD_RX_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    cnt_d = '0;
                    if (byte_data_i == chk_exp) begin
                        cmd_type_d = type_q;
                        cmd_data_d = {hi_q, lo_q};
                        cmd_val_d  = 1'b1;
                        state_d    = S_EMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_EMIT: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is registered from the next state so it drops exactly for the EMIT cycle.
    assign rdy_d     = (state_d != S_EMIT);
    assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            type_q     <= '0;
            hi_q       <= '0;
            cmd_type_q <= '0;
            cmd_data_q <= '0;
            cmd_val_q  <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            rdy_q      <= 1'b0;
`ifdef CMD_RX_CHECKSUM_EN
            lo_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            hi_q       <= hi_d;
            cmd_type_q <= cmd_type_d;
            cmd_data_q <= cmd_data_d;
            cmd_val_q  <= cmd_val_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            rdy_q      <= rdy_d;
`ifdef CMD_RX_CHECKSUM_EN
            lo_q       <= lo_d;
`endif
        end
    end

    assign byte_rdy_o  = rdy_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign cmd_val_o   = cmd_val_q;
    assign frame_err_o = err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_traffic_lights_cmd_rx.sv
// tb/tb_traffic_lights_cmd_rx.sv - scoreboard bench for traffic_lights_cmd_rx
// Follows CMD_RX_CHECKSUM_EN to build 3- or 4-byte frames.
module tb_traffic_lights_cmd_rx;

`ifdef CMD_RX_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_val = 1'b0;
    logic        byte_rdy;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        cmd_val;
    logic        frame_err;
    logic [7:0]  err_cnt;

    traffic_lights_cmd_rx #(
        .SYNC_NIBBLE   (4'hA),
        .CMD_TYPE_MAX  (5),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .byte_data_i(byte_data),
        .byte_val_i (byte_val),
        .byte_rdy_o (byte_rdy),
        .cmd_type_o (cmd_type),
        .cmd_data_o (cmd_data),
        .cmd_val_o  (cmd_val),
        .frame_err_o(frame_err),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [2:0]  t;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int   cmd_cycles[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] t, input logic [15:0] d);
        exp_t e;
        e.is_err = 1'b0; e.t = t; e.d = d;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.t = '0; e.d = '0;
        sb.push_back(e);
        if (exp_cnt < 255) exp_cnt++;
    endtask

    // Strobes are sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (rst_n && (cmd_val || frame_err)) begin
            exp_t e;
            check("strobe_excl", {31'd0, cmd_val & frame_err}, 32'd0);
            check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (cmd_val) begin
                cmd_cycles.push_back(cyc);
                check("rdy_low_in_emit", {31'd0, byte_rdy}, 32'd0);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("event_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                if (!e.is_err && cmd_val) begin
                    check("cmd_type", {29'd0, cmd_type}, {29'd0, e.t});
                    check("cmd_data", {16'd0, cmd_data}, {16'd0, e.d});
                end
            end
        end
    end

    // Called right after a falling edge; returns on the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        bit r;
        bit done = 0;
        byte_data = b;
        byte_val  = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            r = byte_rdy;
            @(negedge clk);
            if (r) done = 1;
        end
        if (!done) check("rdy_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        byte_val = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
`ifdef CMD_RX_CHECKSUM_EN
        send_byte(b0 ^ b1 ^ b2);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("err_cnt", {24'd0, err_cnt}, exp_cnt);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_rdy", {31'd0, byte_rdy}, 32'd0);
        check("rst_outs", {cmd_type, cmd_data, cmd_val, frame_err, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", {31'd0, byte_rdy}, 32'd1);

        // Reset mid-frame discards the partial frame.
        send_byte(8'hA2);
        send_byte(8'h12);
        byte_val = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", {31'd0, byte_rdy}, 32'd0);
        check("midrst_outs", {cmd_type, cmd_data, cmd_val, frame_err, err_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst2", {31'd0, byte_rdy}, 32'd1);
        push_cmd(3'd2, 16'h1234);
        send_frame(8'hA2, 8'h12, 8'h34);
        idle(2);
        drain();

        // Back-to-back frames with byte_val held high.
        cmd_cycles.delete();
        push_cmd(3'd0, 16'h0005);
        push_cmd(3'd5, 16'hFFFF);
        send_frame(8'hA0, 8'h00, 8'h05);
        send_frame(8'hA5, 8'hFF, 8'hFF);
        idle(3);
        drain();
        check("b2b_count", cmd_cycles.size(), 32'd2);
        if (cmd_cycles.size() == 2)
            check("b2b_spacing", cmd_cycles[1] - cmd_cycles[0], FRAME_LEN + 1);

        // Bad headers: sync, type range, bit3.
        push_err(); send_byte(8'h5A);
        push_err(); send_byte(8'hA7);
        idle(2);
        drain();
        push_err(); send_byte(8'hA8);
        push_cmd(3'd1, 16'h0010);
        send_frame(8'hA1, 8'h00, 8'h10);
        idle(2);
        drain();

        // Timeout after 8 idle cycles in LO.
        send_byte(8'hA3);
        send_byte(8'h11);
        push_err();
        idle(7);
        check("no_err_before_to", {31'd0, frame_err}, 32'd0);
        idle(3);
        drain();
        // A byte on the eighth idle cycle wins over the timeout.
        push_cmd(3'd3, 16'h1122);
        send_byte(8'hA3);
        send_byte(8'h11);
        idle(7);
        send_byte(8'h22);
`ifdef CMD_RX_CHECKSUM_EN
        send_byte(8'hA3 ^ 8'h11 ^ 8'h22);
`endif
        idle(3);
        drain();
        push_cmd(3'd4, 16'hBEEF);
        send_frame(8'hA4, 8'hBE, 8'hEF);
        idle(2);
        drain();

`ifdef CMD_RX_CHECKSUM_EN
        push_cmd(3'd2, 16'h1234);
        send_byte(8'hA2); send_byte(8'h12); send_byte(8'h34); send_byte(8'h84);
        push_err();
        send_byte(8'hA2); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        idle(3);
        drain();
`endif

        // Saturating error counter.
        for (int i = 0; i < 300; i++) begin
            push_err();
            send_byte(8'h5A);
        end
        idle(2);
        drain();
        check("sat_255", {24'd0, err_cnt}, 32'd255);
        push_err();
        send_byte(8'hFF);
        idle(2);
        drain();
        check("sat_hold", {24'd0, err_cnt}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        check("global_timeout", 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
